// File: rtl/uart_pkg.sv
// +-------------------------------------------------------------+
// | uart_pkg: shared FSM state encoding and parity selections   |
// | rev 1.0                                                     |
// +-------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

`default_nettype wire

// File: rtl/baud_counter.sv
// +-------------------------------------------------------------+
// | baud_counter: per-bit clock divider, restarted on clr       |
// | rev 1.0                                                     |
// +-------------------------------------------------------------+
`default_nettype none

module baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (clr || cnt == C_LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == C_LAST);
  // pre_tick means the coming clock will be the last one of the bit
  assign pre_tick = !clr && (cnt == C_PRE);

endmodule

`default_nettype wire

// File: rtl/sync_fifo_uart_tx.sv
// +-------------------------------------------------------------+
// | sync_fifo_uart_tx: drains a sync FIFO into UART frames      |
// | rev 1.0                                                     |
// +-------------------------------------------------------------+
`default_nettype none

module sync_fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int D_WIDTH      = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = PAR_NONE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               empty,
  input  logic [D_WIDTH-1:0] r_data,
  output logic               rd,
  output logic               tx,
  output logic               busy,
  output logic               frame_done
);

  localparam int BW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [BW-1:0] C_LAST_BIT = BW'(D_WIDTH - 1);

  state_t             state, state_next;
  logic [D_WIDTH-1:0] shift, shift_next;
  logic [BW-1:0]      bit_cnt, bit_cnt_next;
  logic               par, par_next;
  logic               fetch, clr, tick, pre_tick;
  logic               tx_d, busy_d, done_d;

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    par_next     = par;
    fetch        = 1'b0;
    case (state)
      ST_IDLE:  fetch = en && !empty;
      ST_START: if (tick) state_next = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          par_next   = par ^ shift[0];
          shift_next = shift >> 1;
          if (bit_cnt == C_LAST_BIT) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      ST_PAR:   if (tick) state_next = ST_STOP;
      ST_STOP: begin
        if (tick) begin
          fetch = en && !empty;
          if (!fetch) state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase

    if (fetch) begin
      shift_next   = r_data;
      par_next     = 1'b0;
      bit_cnt_next = '0;
      state_next   = ST_START;
    end

    // rd is held off while in reset so a queued FIFO is never popped
    rd  = fetch && reset;
    clr = (state_next != state);

    // Outputs are registered from the state being entered, so they line
    // up with the state register on the same edge.
    case (state_next)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_next[0];
      ST_PAR:   tx_d = (PARITY == PAR_ODD) ? ~par_next : par_next;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_next != ST_IDLE);
    done_d = (state == ST_STOP) && pre_tick;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par        <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_cnt    <= bit_cnt_next;
      par        <= par_next;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_uart_tx.sv
// +-------------------------------------------------------------+
// | tb_sync_fifo_uart_tx: frame-level model bench, 3 parities   |
// | rev 1.0                                                     |
// +-------------------------------------------------------------+
`default_nettype none

module tb_sync_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int NI  = 3;
  localparam int FDEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] r_data = '0;
  logic [NI-1:0] en = '0;
  logic [NI-1:0] rd, tx, busy, frame_done;

  always #5 clk = ~clk;

  // one instance per parity mode; all share the bench FIFO
  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      sync_fifo_uart_tx #(.D_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY(g)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en[g]),
        .empty      (empty),
        .r_data     (r_data),
        .rd         (rd[g]),
        .tx         (tx[g]),
        .busy       (busy[g]),
        .frame_done (frame_done[g])
      );
    end
  endgenerate

  logic [DW-1:0] q[$];
  logic          pop_pend = 1'b0;
  int n_tests = 0, n_fail = 0, cyc = 0, pops = 0;
  int pos[NI], len[NI], dones[NI], lastf[NI], lastd[NI];
  logic [10:0] fr[NI];
  logic tlog[NI][48];
  int fcyc0[$];
  logic [9:0] pat05 = 10'b1000001010;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h, want %0h", name, k, cyc, act, exp);
    end
  endtask

  function automatic logic [10:0] build(input logic [DW-1:0] b, input int k);
    logic [10:0] f = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (k != 0) f[9] = (^b) ^ (k == 2);
    return f;
  endfunction

  task automatic upd();
    empty  = (q.size() == 0);
    r_data = empty ? '0 : q[0];
  endtask

  task automatic push(input logic [DW-1:0] b);
    if (q.size() < FDEPTH) q.push_back(b);
    upd();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int k, input int n);
    for (int i = 0; i < 400 && dones[k] < n; i++) step(1);
    chk("done_count", k, dones[k], n);
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 100 && pops < n; i++) step(1);
    chk("pop_count", 0, pops, n);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      pos[k] = 0; dones[k] = 0; lastf[k] = 0; lastd[k] = 0;
      len[k] = (10 + ((k != 0) ? 1 : 0)) * CPB;
      fr[k] = '1;
    end
  end

  // Frame model: position within the current frame, frame bits from the byte.
  always @(negedge clk) begin
    logic erd, etx;
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!reset) pos[k] = 0;
      erd = reset && en[k] && !empty && (pos[k] == 0 || pos[k] == len[k]);
      etx = (pos[k] == 0) ? 1'b1 : fr[k][(pos[k]-1)/CPB];
      chk("rd", k, 32'(rd[k]), 32'(erd));
      chk("tx", k, 32'(tx[k]), 32'(etx));
      chk("busy", k, 32'(busy[k]), 32'(pos[k] != 0));
      chk("frame_done", k, 32'(frame_done[k]), 32'(pos[k] == len[k]));
      if (pos[k] > 0 && pos[k] < 48) tlog[k][pos[k]] = tx[k];
      if (frame_done[k]) begin dones[k]++; lastd[k] = cyc; end
      if (erd) begin
        pos[k] = 1;
        fr[k] = build(q[0], k);
        lastf[k] = cyc;
        if (k == 0) fcyc0.push_back(cyc);
      end else if (pos[k] == len[k]) begin
        pos[k] = 0;
      end else if (pos[k] != 0) begin
        pos[k]++;
      end
    end
    pop_pend = |rd;
    if (|rd) pops++;
  end

  // FIFO pops on the rising edge that follows an rd cycle
  always begin
    @(posedge clk);
    #1;
    if (pop_pend) begin
      chk("underflow", 0, 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) void'(q.pop_front());
      pop_pend = 1'b0;
      upd();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    upd();
    // reset held with data queued and enable high
    push(8'h11); en[0] = 1'b1;
    step(6);
    chk("pops_in_reset", 0, pops, 0);
    q.delete(); upd(); en[0] = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);

    // single frame 8'h05, no parity
    push(8'h05); en[0] = 1'b1;
    wait_done(0, 1);
    chk("pops_05", 0, pops, 1);
    chk("len_05", 0, lastd[0] - lastf[0], 40);
    for (int i = 0; i < 10; i++) chk("bit05", i, 32'(tlog[0][i*CPB+2]), 32'(pat05[i]));

    // four back-to-back frames
    for (int i = 0; i < 4; i++) push(8'h06);
    wait_done(0, 5);
    step(2);
    chk("pops_b2b", 0, pops, 5);
    chk("empty_b2b", 0, 32'(empty), 32'd1);
    chk("gap_b2b", 0, fcyc0[2] - fcyc0[1], 40);
    chk("span_b2b", 0, fcyc0[4] - fcyc0[1], 120);
    chk("last_b2b", 0, lastd[0] - fcyc0[4], 40);

    // even and odd parity on 8'h07
    en[0] = 1'b0; en[1] = 1'b1; en[2] = 1'b1;
    push(8'h07);
    wait_done(1, 1);
    wait_done(2, 1);
    chk("len_even", 1, lastd[1] - lastf[1], 44);
    chk("len_odd", 2, lastd[2] - lastf[2], 44);
    chk("par_even", 1, 32'(tlog[1][9*CPB+2]), 32'd1);
    chk("par_odd", 2, 32'(tlog[2][9*CPB+2]), 32'd0);
    chk("pops_par", 0, pops, 6);
    en[1] = 1'b0; en[2] = 1'b0;

    // enable gating with three bytes queued
    push(8'h31); push(8'h32); push(8'h33);
    step(20);
    chk("pops_en0", 0, pops, 6);
    chk("depth_en0", 0, q.size(), 3);
    en[0] = 1'b1;
    wait_pops(7);
    step(10);
    en[0] = 1'b0;
    wait_done(0, 6);
    step(10);
    chk("depth_after_drop", 0, q.size(), 2);
    chk("pops_after_drop", 0, pops, 7);
    chk("len_drop", 0, lastd[0] - lastf[0], 40);

    // reset in the middle of the data bits of 8'hA5
    q.delete(); upd();
    push(8'hA5); push(8'h3C); en[0] = 1'b1;
    wait_pops(8);
    step(14);
    #1 reset = 1'b0;
    #1;
    chk("tx_async_rst", 0, 32'(tx[0]), 32'd1);
    chk("busy_async_rst", 0, 32'(busy[0]), 32'd0);
    chk("rd_in_rst", 0, 32'(rd[0]), 32'd0);
    step(2);
    reset = 1'b1;
    wait_done(0, 7);
    step(3);
    chk("pops_after_rst", 0, pops, 9);
    chk("depth_after_rst", 0, q.size(), 0);
    chk("len_after_rst", 0, lastd[0] - lastf[0], 40);
    en[0] = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sync_fifo_uart_tx.md
# sync_fifo_uart_tx

Serial transmit stage that drains the synchronous FIFO (`sync_fifo_rtl`) and serialises each byte as an asynchronous UART frame. It sits directly downstream of the FIFO: it watches `empty`, samples the FIFO's head-of-queue `r_data`, and pops the FIFO with a one-cycle `rd` pulse per frame. Frame format is start bit, D_WIDTH data bits LSB-first, optional parity, and one stop bit, each held for CLKS_PER_BIT clocks.

## Interface
- `D_WIDTH`, 8: data bits per frame; matches FIFO `D_WIDTH`.
- `CLKS_PER_BIT`, 16: clocks per serial bit, ≥2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  transmit enable; gates the start of new frames only.
- `empty`  in  1  FIFO empty flag.
- `r_data`  in  D_WIDTH  FIFO head-of-queue data; valid whenever `empty`=0, independent of `rd`.
- `rd`  out  1  FIFO pop strobe, one cycle per frame.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high from the fetch cycle through the last stop-bit clock.
- `frame_done`  out  1  one-cycle pulse on the last clock of each stop bit.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: `tx`=1. If `en`=1 and `empty`=0, do the following in that cycle:
  - assert `rd`;
  - load `r_data` into the shift register;
  - clear the parity accumulator;
  - move to START.
- START: `tx`=0 for CLKS_PER_BIT clocks, then DATA.
- DATA: `tx`=shift[0] for CLKS_PER_BIT clocks, then shift right. The bit counter runs 0..D_WIDTH-1. After the last bit, go to PAR if PARITY≠0, otherwise to STOP.
- PAR: for CLKS_PER_BIT clocks, `tx` = XOR of the data bits for even parity, or its inverse for odd parity. Then STOP.
- STOP: `tx`=1 for CLKS_PER_BIT clocks. On the last clock, pulse `frame_done`. On that same last clock:
  - if `en`=1 and `empty`=0, assert `rd`, load `r_data`, and go directly to START (back-to-back frames, no idle gap);
  - otherwise, go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, reloads to 0 on every state entry, and wraps without overflow.
- `en` deasserted mid-frame: the current frame completes; no further pops occur.
- `empty` is sampled only in the fetch cycle. Changes to `empty` during a frame are ignored.
- `rd` is never asserted while `empty`=1, so the FIFO is never underflowed.

## Timing
- Reset values: `tx`=1, `rd`=0, `busy`=0, `frame_done`=0, state=IDLE, all counters 0. Reset mid-frame aborts the frame immediately; `tx` returns high asynchronously.
- Latency: the falling edge of `tx` (start bit) appears on the clock edge after the fetch cycle.
- Frame length: (1 + D_WIDTH + (PARITY≠0) + 1) × CLKS_PER_BIT clocks.
- `rd` is registered-free combinational decode of state, `en` and `empty`. It is high for exactly one cycle per frame, so the FIFO pops on that rising edge.
- `tx`, `busy` and `frame_done` are registered; they have no combinational path from inputs.
- Simultaneous FIFO write and this block's `rd` in the same cycle is legal; the FIFO handles it.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants (IDLE=0 … STOP=4);
  - PARITY encodings `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
- One sub-module, `baud_counter`. Parameter: CLKS_PER_BIT. Inputs: `clk`, `reset`, `clr`. Output: `tick`, high on the last clock of each bit.
- The top level holds the FSM, shift register, bit counter and parity accumulator.

## Test plan
Bench parameters: CLKS_PER_BIT=4, D_WIDTH=8, connected to `sync_fifo_rtl` with DEPTH=8.
- Reset low with FIFO non-empty: `tx`=1, `rd`=0, `busy`=0 throughout; no pop occurs.
- Write 8'h05, en=1, PARITY=0: one `rd` pulse. `tx` sequence is 0,1,0,1,0,0,0,0,0,1, each held 4 clocks (40 clocks total); `frame_done` pulses once.
- Write 8'h06 four times, en=1: four frames back-to-back with no idle cycle between stop and start; four `rd` pulses; `empty`=1 afterwards.
- PARITY=1 with byte 8'h07: parity bit = 1. PARITY=2 with byte 8'h07: parity bit = 0. Frame length is 44 clocks in both cases.
- en=0 with 3 bytes queued: no `rd` and `tx` stays 1. Raise en, then drop it mid-first-frame: that frame completes, and 2 bytes remain in the FIFO.
- Reset asserted during DATA of byte 8'hA5: `tx`=1 and state is IDLE immediately. After release, the next queued byte transmits cleanly; the aborted byte is not resent.
